// File: rtl/bpsk_pkg.sv
// BPSK receive-chain shared definitions.
// Sample format and saturating accumulator add.
package bpsk_pkg;

   localparam int SYMBOL_WIDTH = 16;
   localparam int SYMBOL_FRAC  = 14;

   typedef logic signed [SYMBOL_WIDTH-1:0] sample_t;

   // Add two sign-extended values and clamp to a w-bit signed range.
   function automatic logic signed [63:0] sat_add(
      input logic signed [63:0] a,
      input logic signed [63:0] b,
      input int                 w
   );
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = a + b;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (s > hi) begin
         sat_add = hi;
      end else if (s < lo) begin
         sat_add = lo;
      end else begin
         sat_add = s;
      end
   endfunction

endpackage

// File: rtl/gardner_ted.sv
// Gardner timing error detector.
// e = (mid * (prev_on - on)) >>> F, truncated to W+2 bits.
module gardner_ted
   import bpsk_pkg::*;
#(
   parameter int W = SYMBOL_WIDTH,
   parameter int F = SYMBOL_FRAC
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_en,
   input  logic                i_mid_stb,
   input  logic                i_on_stb,
   input  logic signed [W-1:0] i_sample,
   output logic                o_valid,
   output logic signed [W+1:0] o_err
);

   localparam int PW = 2 * W + 1;

   logic signed [W-1:0]  r_mid;
   logic signed [W-1:0]  r_prev_on;
   logic signed [PW-1:0] r_prod;
   logic                 r_valid;

   logic signed [W:0]    w_diff;
   logic signed [PW-1:0] w_prod;
   logic                 w_unused_prod;

   assign w_diff = {r_prev_on[W-1], r_prev_on}
                 - {i_sample[W-1], i_sample};

   assign w_prod = $signed({{(W + 1){r_mid[W-1]}}, r_mid})
                 * $signed({{W{w_diff[W]}}, w_diff});

   // Bit slice of the full product is the truncated arithmetic shift.
   assign o_err         = r_prod[F+W+1:F];
   assign w_unused_prod = ^{r_prod[PW-1:F+W+2], r_prod[F-1:0]};
   assign o_valid       = r_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mid     <= '0;
         r_prev_on <= '0;
         r_prod    <= '0;
         r_valid   <= 1'b0;
      end else if (i_en) begin
         r_valid <= i_on_stb;
         if (i_mid_stb) begin
            r_mid <= i_sample;
         end
         if (i_on_stb) begin
            r_prod    <= w_prod;
            r_prev_on <= i_sample;
         end
      end
   end

endmodule

// File: rtl/symbol_timing_recovery.sv
// Symbol timing recovery with Gardner TED and BPSK hard slicer.
// Period is nudged by one sample for one symbol per window.
module symbol_timing_recovery
   import bpsk_pkg::*;
#(
   parameter int SYMBOL_WIDTH = bpsk_pkg::SYMBOL_WIDTH,
   parameter int SYMBOL_FRAC  = bpsk_pkg::SYMBOL_FRAC,
   parameter int SPS          = 8,
   parameter int ACC_LEN      = 16,
   parameter int THRESH       = 32768,
   parameter int ACC_WIDTH    = 32,
   parameter int LOCK_WINDOWS = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         new_sample,
   input  logic signed [SYMBOL_WIDTH-1:0] in_sample,
   output logic                         sym_valid,
   output logic signed [SYMBOL_WIDTH-1:0] sym_out,
   output logic                         bit_out,
   output logic signed [SYMBOL_WIDTH+1:0] timing_err,
   output logic                         locked
);

   localparam int CW  = $clog2(SPS + 2);
   localparam int SCW = $clog2(ACC_LEN + 1);
   localparam int LCW = $clog2(LOCK_WINDOWS + 1);
   localparam int EW  = SYMBOL_WIDTH + 2;

   localparam logic [CW-1:0] P_NOM   = CW'(SPS);
   localparam logic [CW-1:0] P_RET   = CW'(SPS + 1);
   localparam logic [CW-1:0] P_ADV   = CW'(SPS - 1);
   localparam logic [CW-1:0] MID_IDX = CW'(SPS / 2 - 1);

   localparam logic signed [ACC_WIDTH-1:0] THR_P = ACC_WIDTH'(THRESH);
   localparam logic signed [ACC_WIDTH-1:0] THR_N = -THR_P;

   logic [CW-1:0]                  r_cnt;
   logic [CW-1:0]                  r_period;
   logic signed [ACC_WIDTH-1:0]    r_acc;
   logic [SCW-1:0]                 r_nsym;
   logic [LCW-1:0]                 r_lock_cnt;
   logic                           r_locked;
   logic                           r_sym_valid;
   logic signed [SYMBOL_WIDTH-1:0] r_sym;
   logic                           r_bit;

   logic                           w_take;
   logic                           w_wrap;
   logic                           w_on;
   logic                           w_mid;
   logic                           w_ted_valid;
   logic signed [EW-1:0]           w_err;
   logic signed [63:0]             w_sum;
   logic signed [ACC_WIDTH-1:0]    w_acc_next;
   logic                           w_unused_sum;
   logic                           w_win_end;
   logic [LCW-1:0]                 w_lock_inc;

   assign w_take = en && new_sample;
   assign w_wrap = (r_cnt == r_period - CW'(1));
   assign w_on   = w_take && w_wrap;
   assign w_mid  = w_take && (r_cnt == MID_IDX);

   gardner_ted #(
      .W (SYMBOL_WIDTH),
      .F (SYMBOL_FRAC)
   ) u_ted (
      .clk       (clk),
      .rst       (rst),
      .i_en      (en),
      .i_mid_stb (w_mid),
      .i_on_stb  (w_on),
      .i_sample  (in_sample),
      .o_valid   (w_ted_valid),
      .o_err     (w_err)
   );

   assign w_sum = sat_add(
      {{(64 - ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc},
      {{(64 - EW){w_err[EW-1]}}, w_err},
      ACC_WIDTH);
   assign w_acc_next   = w_sum[ACC_WIDTH-1:0];
   assign w_unused_sum = ^w_sum[63:ACC_WIDTH];

   assign w_win_end  = (r_nsym == SCW'(ACC_LEN - 1));
   assign w_lock_inc = (r_lock_cnt == LCW'(LOCK_WINDOWS))
                     ? r_lock_cnt : r_lock_cnt + LCW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_period    <= P_NOM;
         r_acc       <= '0;
         r_nsym      <= '0;
         r_lock_cnt  <= '0;
         r_locked    <= 1'b0;
         r_sym_valid <= 1'b0;
         r_sym       <= '0;
         r_bit       <= 1'b0;
      end else if (en) begin
         r_sym_valid <= w_on;
         if (w_on) begin
            r_sym <= in_sample;
            r_bit <= ~in_sample[SYMBOL_WIDTH-1];
         end
         // An adjusted period lasts one symbol, then reverts.
         if (new_sample) begin
            if (w_wrap) begin
               r_cnt    <= '0;
               r_period <= P_NOM;
            end else begin
               r_cnt <= r_cnt + CW'(1);
            end
         end
         if (w_ted_valid) begin
            if (w_win_end) begin
               r_acc  <= '0;
               r_nsym <= '0;
               if (w_acc_next > THR_P) begin
                  r_period   <= P_RET;
                  r_lock_cnt <= '0;
                  r_locked   <= 1'b0;
               end else if (w_acc_next < THR_N) begin
                  r_period   <= P_ADV;
                  r_lock_cnt <= '0;
                  r_locked   <= 1'b0;
               end else begin
                  r_period   <= P_NOM;
                  r_lock_cnt <= w_lock_inc;
                  r_locked   <= (w_lock_inc == LCW'(LOCK_WINDOWS));
               end
            end else begin
               r_acc  <= w_acc_next;
               r_nsym <= r_nsym + SCW'(1);
            end
         end
      end
   end

   assign sym_valid  = r_sym_valid;
   assign sym_out    = r_sym;
   assign bit_out    = r_bit;
   assign timing_err = w_err;
   assign locked     = r_locked;

endmodule

// File: tb/tb_symbol_timing_recovery.sv
// Bench for symbol_timing_recovery: symbol-level reference model
// compared every cycle, plus literal expectations per scenario.
module tb_symbol_timing_recovery;

   localparam int SPS     = 8;
   localparam int ACC_LEN = 16;
   localparam int THRESH  = 32768;
   localparam int LW      = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic               new_sample;
   logic signed [15:0] in_sample;
   logic               sym_valid;
   logic signed [15:0] sym_out;
   logic               bit_out;
   logic signed [17:0] timing_err;
   logic               locked;

   always #5 clk = ~clk;

   symbol_timing_recovery dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .new_sample (new_sample),
      .in_sample  (in_sample),
      .sym_valid  (sym_valid),
      .sym_out    (sym_out),
      .bit_out    (bit_out),
      .timing_err (timing_err),
      .locked     (locked)
   );

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_on = 0;

   task automatic chk(input string nm, input longint got,
                      input longint want);
      n_chk++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got %0d want %0d at %0t",
                  nm, got, want, $time);
      end
   endtask

   // Reference model: position within the current symbol and its length
   int     m_pos, m_len, m_nsym, m_lock;
   longint m_acc, m_prev, m_mid, m_pend_e;
   bit     m_pend;
   bit     m_valid, m_bit, m_locked;
   longint m_sym, m_err;

   function automatic longint floor_div(input longint p);
      if (p >= 0) return p / 16384;
      return -((-p + 16383) / 16384);
   endfunction

   function automatic longint sat32(input longint x);
      if (x > 64'sd2147483647) return 64'sd2147483647;
      if (x < -64'sd2147483648) return -64'sd2147483648;
      return x;
   endfunction

   task automatic model_edge(input bit r, input bit e, input bit ns,
                             input longint v);
      if (r) begin
         m_pos = 0; m_len = SPS; m_nsym = 0; m_lock = 0;
         m_acc = 0; m_prev = 0; m_mid = 0; m_pend = 0;
         m_pend_e = 0; m_valid = 0; m_bit = 0; m_locked = 0;
         m_sym = 0; m_err = 0;
         return;
      end
      if (!e) return;
      if (m_pend) begin
         m_pend = 0;
         m_acc  = sat32(m_acc + m_pend_e);
         m_nsym++;
         if (m_nsym == ACC_LEN) begin
            if (m_acc > THRESH) begin
               m_len = SPS + 1; m_lock = 0;
            end else if (m_acc < -THRESH) begin
               m_len = SPS - 1; m_lock = 0;
            end else if (m_lock < LW) begin
               m_lock++;
            end
            m_locked = (m_lock == LW);
            m_acc = 0; m_nsym = 0;
         end
      end
      m_valid = 0;
      if (ns) begin
         m_pos++;
         if (m_pos == SPS / 2) m_mid = v;
         if (m_pos == m_len) begin
            m_valid  = 1;
            m_sym    = v;
            m_bit    = (v >= 0);
            m_err    = floor_div(m_mid * (m_prev - v));
            m_prev   = v;
            m_pend   = 1;
            m_pend_e = m_err;
            m_pos    = 0;
            m_len    = SPS;
         end
      end
   endtask

   task automatic step(input bit r, input bit e, input bit ns,
                       input logic signed [15:0] v);
      rst = r; en = e; new_sample = ns; in_sample = v;
      @(posedge clk);
      model_edge(r, e, ns, longint'(v));
      #2;
   endtask

   // Symbol-aligned stimulus generator
   int     g_idx  = 0;
   longint g_prev = 0;

   function automatic longint sgn(input longint x);
      if (x > 0) return 1;
      if (x < 0) return -1;
      return 0;
   endfunction

   task automatic send(input bit e_n, input int mode);
      int     p;
      longint v, on_v, d;
      p    = m_pos + 1;
      on_v = (mode == 0 || g_idx % 2 == 0) ? 8192 : -8192;
      d    = g_prev - on_v;
      if (!e_n) begin
         v = 12345;
      end else if (p == m_len) begin
         v = on_v; g_prev = on_v; g_idx++;
      end else if (p == SPS / 2) begin
         case (mode)
            0:       v = 8192;
            1:       v = 0;
            2:       v = 4096 * sgn(d);
            default: v = -4096 * sgn(d);
         endcase
      end else begin
         v = 1000;
      end
      step(0, e_n, 1, 16'(v));
   endtask

   task automatic send_syms(input int n, input int mode);
      int tgt, guard;
      tgt = g_idx + n;
      guard = 0;
      while (g_idx < tgt && guard < n * 20) begin
         send(1, mode);
         guard++;
      end
      chk("send_budget", longint'(g_idx), longint'(tgt));
   endtask

   task automatic do_reset();
      step(1, 1, 1, 16'sd777);
      g_idx = 0; g_prev = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 0, 16'sd0);
   endtask

   // Rising-edge interval tracker on sym_valid
   int cyc = 0, last_rise = -1, iv_min = 1000, iv_max = 0;
   bit sv_prev = 0;

   task automatic trk_clear();
      last_rise = -1; iv_min = 1000; iv_max = 0;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (chk_on) begin
            chk("sym_valid",  longint'(sym_valid), longint'(m_valid));
            chk("sym_out",    longint'(sym_out), m_sym);
            chk("bit_out",    longint'(bit_out), longint'(m_bit));
            chk("timing_err", longint'(timing_err), m_err);
            chk("locked",     longint'(locked), longint'(m_locked));
            if (sym_valid && !sv_prev) begin
               if (last_rise >= 0) begin
                  if (cyc - last_rise < iv_min) iv_min = cyc - last_rise;
                  if (cyc - last_rise > iv_max) iv_max = cyc - last_rise;
               end
               last_rise = cyc;
            end
            sv_prev = sym_valid;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      step(1, 0, 0, 16'sd0);
      step(1, 0, 0, 16'sd0);
      chk("rst_sym_valid",  longint'(sym_valid), 0);
      chk("rst_sym_out",    longint'(sym_out), 0);
      chk("rst_bit_out",    longint'(bit_out), 0);
      chk("rst_timing_err", longint'(timing_err), 0);
      chk("rst_locked",     longint'(locked), 0);
      chk_on = 1;

      // Constant +8192: no adjustment, lock after 64 symbols
      trk_clear();
      send_syms(64, 0);
      idle(3);
      chk("p1_locked", longint'(locked), 1);
      chk("p1_sym",    longint'(sym_out), 8192);
      chk("p1_bit",    longint'(bit_out), 1);
      chk("p1_err",    longint'(timing_err), 0);
      chk("p1_iv_min", longint'(iv_min), 8);
      chk("p1_iv_max", longint'(iv_max), 8);

      // Negative mid on transitions: advance, lock drops
      trk_clear();
      send_syms(18, 3);
      idle(3);
      chk("p4_locked", longint'(locked), 0);
      chk("p4_iv_min", longint'(iv_min), 7);
      chk("p4_err",    longint'(timing_err), -4096);

      // Alternating symbols, mid 0
      do_reset();
      trk_clear();
      send_syms(64, 1);
      idle(3);
      chk("p2_locked", longint'(locked), 1);
      chk("p2_iv_min", longint'(iv_min), 8);
      chk("p2_iv_max", longint'(iv_max), 8);
      chk("p2_bit",    longint'(bit_out), 0);

      // Positive mid on transitions: retard
      do_reset();
      trk_clear();
      send_syms(18, 2);
      idle(3);
      chk("p3_locked", longint'(locked), 0);
      chk("p3_iv_max", longint'(iv_max), 9);
      chk("p3_err",    longint'(timing_err), 4096);

      // en toggling every cycle with new_sample held high
      do_reset();
      trk_clear();
      for (int i = 0; i < 200 && g_idx < 10; i++) begin
         send(1, 0);
         send(0, 0);
      end
      idle(2);
      chk("p5_syms",   longint'(g_idx), 10);
      chk("p5_iv_min", longint'(iv_min), 16);
      chk("p5_iv_max", longint'(iv_max), 16);

      // Reset at symbol 10 of a window
      do_reset();
      send_syms(10, 2);
      do_reset();
      trk_clear();
      chk("p6_rst_valid", longint'(sym_valid), 0);
      chk("p6_rst_sym",   longint'(sym_out), 0);
      chk("p6_rst_bit",   longint'(bit_out), 0);
      chk("p6_rst_err",   longint'(timing_err), 0);
      chk("p6_rst_lock",  longint'(locked), 0);
      lat = 0;
      while (!sym_valid && lat < 20) begin
         send(1, 2);
         lat++;
      end
      chk("p6_first_lat", longint'(lat), 8);
      send_syms(20, 2);
      idle(3);
      chk("p6_iv_max", longint'(iv_max), 9);
      chk("p6_locked", longint'(locked), 0);

      chk_on = 0;
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
